// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared constants, FSM encoding and address helpers for the MEM stage.
package mem_stage_pkg;
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;
  localparam int DEPTH_DEF = 256;
  localparam int IDX_HI = 9;
  localparam int IDX_LO = 2;
  localparam int IDX_W = IDX_HI - IDX_LO + 1;
  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;
  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
    return addr[IDX_HI:IDX_LO];
  endfunction
endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: EX/MEM inputs and MEM/WB outputs of the memory stage.
interface mem_stage_if;
  logic [1:0] Mem_WB;
  logic read_En;
  logic write_En;
  logic Mem_Br;
  logic Zero;
  logic [31:0] DataAddress;
  logic [31:0] WriteData;
  logic [4:0] dest;
  logic [1:0] Wb;
  logic [31:0] ReadData;
  logic [31:0] ALUResult;
  logic [4:0] Write_Register;
  logic PCSrc;
  logic stall;
  logic misalign;
  modport master (
    output Mem_WB, read_En, write_En, Mem_Br, Zero, DataAddress, WriteData, dest,
    input Wb, ReadData, ALUResult, Write_Register, PCSrc, stall, misalign
  );
  modport slave (
    input Mem_WB, read_En, write_En, Mem_Br, Zero, DataAddress, WriteData, dest,
    output Wb, ReadData, ALUResult, Write_Register, PCSrc, stall, misalign
  );
endinterface

// File: rtl/mem_stage_mem2wb.sv
// mem2wb: MEM/WB pipeline register; a bubble zeroes Wb and holds the other fields.
module mem2wb (
  input  logic        clk,
  input  logic        rst,
  input  logic        bubble,
  input  logic        load,
  input  logic [1:0]  wb_d,
  input  logic [31:0] alu_d,
  input  logic [4:0]  dest_d,
  input  logic [31:0] rdata_d,
  output logic [1:0]  wb_q,
  output logic [31:0] alu_q,
  output logic [4:0]  dest_q,
  output logic [31:0] rdata_q
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wb_q <= '0;
      alu_q <= '0;
      dest_q <= '0;
      rdata_q <= '0;
    end else if (bubble) begin
      wb_q <= '0;
    end else begin
      wb_q <= wb_d;
      alu_q <= alu_d;
      dest_q <= dest_d;
      if (load) rdata_q <= rdata_d;
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: data memory with programmable wait states, branch resolve and MEM/WB register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int DEPTH = DEPTH_DEF
) (
  input logic clk,
  input logic rst,
  mem_stage_if.slave bus
);
  state_t state;
  logic [3:0] cnt;
  logic [31:0] mem [DEPTH];
  logic [IDX_W-1:0] idx;
  logic acc, aligned, go, stall, done, mem_wr, load;
  logic [31:0] rdata;
  assign idx = word_idx(bus.DataAddress);
  assign acc = bus.read_En | bus.write_En;
  assign aligned = bus.DataAddress[1:0] == 2'b00;
  assign go = acc && aligned;
  assign bus.PCSrc = bus.Mem_Br & bus.Zero;
  assign bus.stall = stall;
  // Misaligned accesses never enter WAIT; they complete immediately as faults.
  always_comb begin
    stall = (WAIT_CYCLES != 0) && (state == S_WAIT ? (cnt != 4'd0) : go);
    done = acc && !stall;
    mem_wr = done && aligned && bus.write_En && rst;
    load = done && bus.read_En && !bus.write_En;
    rdata = aligned ? mem[idx] : '0;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= S_IDLE;
      cnt <= '0;
      bus.misalign <= 1'b0;
    end else begin
      if (acc && !aligned) bus.misalign <= 1'b1;
      if (state == S_IDLE && go && WAIT_CYCLES != 0) begin
        state <= S_WAIT;
        cnt <= 4'(WAIT_CYCLES - 1);
      end else if (state == S_WAIT) begin
        if (cnt == 4'd0) state <= S_IDLE;
        else cnt <= cnt - 4'd1;
      end
    end
  always_ff @(posedge clk)
    if (mem_wr) mem[idx] <= bus.WriteData;
  mem2wb u_mem2wb (
    .clk     (clk),
    .rst     (rst),
    .bubble  (stall),
    .load    (load),
    .wb_d    (bus.Mem_WB),
    .alu_d   (bus.DataAddress),
    .dest_d  (bus.dest),
    .rdata_d (rdata),
    .wb_q    (bus.Wb),
    .alu_q   (bus.ALUResult),
    .dest_q  (bus.Write_Register),
    .rdata_q (bus.ReadData)
  );
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: three instances (0/1/3 wait states) driven in turn against a memory-array model.
module tb_mem_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int sel = 0;
  logic rd = 0, wr = 0, br = 0, zero = 0;
  logic [31:0] addr = '0, wdata = '0;
  logic [1:0] mwb = '0;
  logic [4:0] dst = '0;

  mem_stage_if b0 ();
  mem_stage_if b1 ();
  mem_stage_if b3 ();

  mem_stage #(.WAIT_CYCLES(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
  mem_stage #(.WAIT_CYCLES(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  mem_stage #(.WAIT_CYCLES(3)) u3 (.clk(clk), .rst(rst), .bus(b3));

  assign b0.read_En = rd && sel == 0;
  assign b0.write_En = wr && sel == 0;
  assign b0.Mem_WB = mwb;
  assign b0.Mem_Br = br;
  assign b0.Zero = zero;
  assign b0.DataAddress = addr;
  assign b0.WriteData = wdata;
  assign b0.dest = dst;
  assign b1.read_En = rd && sel == 1;
  assign b1.write_En = wr && sel == 1;
  assign b1.Mem_WB = mwb;
  assign b1.Mem_Br = br;
  assign b1.Zero = zero;
  assign b1.DataAddress = addr;
  assign b1.WriteData = wdata;
  assign b1.dest = dst;
  assign b3.read_En = rd && sel == 2;
  assign b3.write_En = wr && sel == 2;
  assign b3.Mem_WB = mwb;
  assign b3.Mem_Br = br;
  assign b3.Zero = zero;
  assign b3.DataAddress = addr;
  assign b3.WriteData = wdata;
  assign b3.dest = dst;

  logic [1:0] o_wb;
  logic [31:0] o_rd, o_alu;
  logic [4:0] o_wr;
  logic o_pcsrc, o_stall, o_mis;
  always_comb begin
    o_wb = sel == 0 ? b0.Wb : sel == 1 ? b1.Wb : b3.Wb;
    o_rd = sel == 0 ? b0.ReadData : sel == 1 ? b1.ReadData : b3.ReadData;
    o_alu = sel == 0 ? b0.ALUResult : sel == 1 ? b1.ALUResult : b3.ALUResult;
    o_wr = sel == 0 ? b0.Write_Register : sel == 1 ? b1.Write_Register : b3.Write_Register;
    o_pcsrc = sel == 0 ? b0.PCSrc : sel == 1 ? b1.PCSrc : b3.PCSrc;
    o_stall = sel == 0 ? b0.stall : sel == 1 ? b1.stall : b3.stall;
    o_mis = sel == 0 ? b0.misalign : sel == 1 ? b1.misalign : b3.misalign;
  end

  int checks = 0, failures = 0;
  int wc [3] = '{0, 1, 3};
  logic [31:0] mdl [3][256];
  logic [31:0] exp_rd [3];
  bit rd_known [3];
  bit exp_mis [3];
  logic [1:0] exp_wb;
  logic [31:0] exp_alu;
  logic [4:0] exp_wr;

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      exp_rd[k] = '0;
      rd_known[k] = 1;
      exp_mis[k] = 0;
    end
    exp_wb = '0;
    exp_alu = '0;
    exp_wr = '0;
  endtask

  task automatic check_outputs(input int k, input string tag);
    checks++;
    if (o_wb !== exp_wb) begin failures++; $display("FAIL %s_wb k=%0d got=%b exp=%b", tag, k, o_wb, exp_wb); end
    checks++;
    if (o_alu !== exp_alu) begin failures++; $display("FAIL %s_alu k=%0d got=%h exp=%h", tag, k, o_alu, exp_alu); end
    checks++;
    if (o_wr !== exp_wr) begin failures++; $display("FAIL %s_wreg k=%0d got=%0d exp=%0d", tag, k, o_wr, exp_wr); end
    checks++;
    if (o_mis !== exp_mis[k]) begin failures++; $display("FAIL %s_misalign k=%0d got=%b exp=%b", tag, k, o_mis, exp_mis[k]); end
    if (rd_known[k]) begin
      checks++;
      if (o_rd !== exp_rd[k]) begin failures++; $display("FAIL %s_rdata k=%0d got=%h exp=%h", tag, k, o_rd, exp_rd[k]); end
    end
  endtask

  // One instruction on instance k: aligned accesses take wc[k] stall cycles plus one completing cycle.
  task automatic access(input int k, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] m, input logic [4:0] ds);
    int n;
    bit al;
    al = a[1:0] == 2'b00;
    n = ((r || w) && al) ? wc[k] : 0;
    sel = k; rd = r; wr = w; addr = a; wdata = d; mwb = m; dst = ds;
    for (int i = 0; i <= n; i++) begin
      br = 1'($urandom); zero = 1'($urandom);
      #1;
      checks++;
      if (o_pcsrc !== (br & zero)) begin failures++; $display("FAIL pcsrc k=%0d got=%b exp=%b", k, o_pcsrc, br & zero); end
      checks++;
      if (o_stall !== 1'(i < n)) begin failures++; $display("FAIL stall k=%0d cyc=%0d got=%b exp=%b", k, i, o_stall, i < n); end
      @(posedge clk);
      #1;
      if (i < n) begin
        checks++;
        if (o_wb !== 2'b00) begin failures++; $display("FAIL bubble_wb k=%0d got=%b exp=00", k, o_wb); end
        checks++;
        if (o_alu !== exp_alu) begin failures++; $display("FAIL bubble_alu k=%0d got=%h exp=%h", k, o_alu, exp_alu); end
      end else begin
        if ((r || w) && !al) exp_mis[k] = 1;
        if (w && al) mdl[k][a[9:2]] = d;
        if (r && !w) begin
          exp_rd[k] = al ? mdl[k][a[9:2]] : 32'h0;
          rd_known[k] = 1;
        end else if (r && w) rd_known[k] = 0;
        exp_wb = m; exp_alu = a; exp_wr = ds;
        check_outputs(k, "op");
      end
      @(negedge clk);
    end
    rd = 0; wr = 0;
  endtask

  task automatic test_reset();
    model_reset();
    rst = 0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      sel = k;
      #1;
      checks++;
      if (o_stall !== 1'b0) begin failures++; $display("FAIL reset_stall k=%0d got=%b exp=0", k, o_stall); end
      check_outputs(k, "reset");
    end
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_fill();
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 16; j++)
        access(k, 0, 1, 32'(j << 2), $urandom, 2'b00, 5'd0);
  endtask

  task automatic test_wait1_store_load();
    access(1, 0, 1, 32'h10, 32'hDEADBEEF, 2'b10, 5'd3);
    access(1, 1, 0, 32'h10, 32'h0, 2'b11, 5'd4);
    checks++;
    if (o_rd !== 32'hDEADBEEF) begin failures++; $display("FAIL w1_load got=%h exp=deadbeef", o_rd); end
  endtask

  task automatic test_back_to_back();
    access(0, 0, 1, 32'h4, 32'd5, 2'b10, 5'd1);
    access(0, 1, 0, 32'h4, 32'h0, 2'b11, 5'd2);
    checks++;
    if (o_rd !== 32'd5) begin failures++; $display("FAIL b2b_load got=%h exp=5", o_rd); end
  endtask

  task automatic test_misalign();
    access(0, 0, 1, 32'h6, 32'h12345678, 2'b10, 5'd9);
    access(0, 1, 0, 32'h4, 32'h0, 2'b11, 5'd9);
    access(2, 1, 0, 32'h21, 32'h0, 2'b11, 5'd10);
    access(1, 1, 1, 32'h8, 32'hA5A5A5A5, 2'b10, 5'd11);
    access(1, 1, 0, 32'h8, 32'h0, 2'b11, 5'd11);
  endtask

  task automatic test_random();
    for (int t = 0; t < 200; t++) begin
      int k, kind;
      logic [31:0] a;
      k = $urandom_range(0, 2);
      kind = $urandom_range(0, 9);
      a = $urandom;
      if (kind < 9) begin
        a[9:2] = 8'($urandom_range(0, 15));
        a[1:0] = 2'b00;
      end else a[1:0] = 2'($urandom_range(1, 3));
      if (kind < 4 || kind == 9) access(k, 1, 0, a, $urandom, 2'($urandom), 5'($urandom));
      else if (kind < 7) access(k, 0, 1, a, $urandom, 2'($urandom), 5'($urandom));
      else access(k, 0, 0, $urandom, $urandom, 2'($urandom), 5'($urandom));
    end
  endtask

  task automatic test_reset_mid_wait();
    sel = 2; rd = 0; wr = 1; addr = 32'(5 << 2); wdata = ~mdl[2][5]; mwb = 2'b11; dst = 5'd7;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
    #1;
    check_outputs(2, "midrst");
    wr = 0;
    @(negedge clk);
    rst = 1;
    access(2, 1, 0, 32'(5 << 2), 32'h0, 2'b10, 5'd8);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_wait1_store_load();
    test_back_to_back();
    test_misalign();
    test_random();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameters (name, default, meaning): WAIT_CYCLES, 1, extra cycles per load/store (0..15); DEPTH, 256, data memory words.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 Mem_WB  in  2  WB control from EX/MEM register; [1]=RegWrite, [0]=MemToReg.
REQ-005 read_En  in  1  load request.
REQ-006 write_En  in  1  store request.
REQ-007 Mem_Br  in  1  branch instruction flag.
REQ-008 Zero  in  1  ALU zero flag.
REQ-009 DataAddress  in  32  ALU result / byte address.
REQ-010 WriteData  in  32  store data.
REQ-011 dest  in  5  destination register.
REQ-012 Wb  out  2  registered WB control to writeback.
REQ-013 ReadData  out  32  registered load data.
REQ-014 ALUResult  out  32  registered DataAddress.
REQ-015 Write_Register  out  5  registered dest.
REQ-016 PCSrc  out  1  combinational branch-taken.
REQ-017 stall  out  1  combinational; upstream holds EX/MEM while high.
REQ-018 misalign  out  1  registered sticky alignment-fault flag.

Function
REQ-019 PCSrc SHALL equal Mem_Br AND Zero, combinationally, independent of stall.
REQ-020 Memory SHALL be word-organised, DEPTH x 32, indexed by DataAddress[9:2]; upper address bits ignored.
REQ-021 FSM states IDLE, WAIT; 4-bit counter cnt.
REQ-022 IDLE, access request (read_En or write_En), WAIT_CYCLES>0: stall=1, cnt<=WAIT_CYCLES-1, go WAIT.
REQ-023 WAIT, cnt!=0: stall=1, cnt decrements; cnt==0: stall=0, access completes this cycle, go IDLE.
REQ-024 WAIT_CYCLES=0: every access completes in IDLE in one cycle; stall never asserted.
REQ-025 Completing store SHALL write WriteData at the clock edge ending the completing cycle.
REQ-026 Completing load SHALL capture mem[index] into ReadData at that edge; read-before-write not applicable (load and store mutually exclusive).
REQ-027 read_En and write_En both high: treated as store only; load data undefined, Wb still registered.
REQ-028 Non-access cycles: MEM/WB register captures Mem_WB, DataAddress, dest every edge; ReadData holds.
REQ-029 Any stall=1 cycle SHALL load a bubble: Wb=2'b00, other MEM/WB fields hold.
REQ-030 Access with DataAddress[1:0]!=0: store suppressed, load returns 0, misalign set and held until reset; no wait states inserted; Wb still passed.
REQ-031 Latency: results visible on outputs one cycle after completing cycle; load-to-Wb total = WAIT_CYCLES+1 cycles.

Reset
REQ-032 rst low SHALL asynchronously force state IDLE, cnt=0, Wb=0, ReadData=0, ALUResult=0, Write_Register=0, misalign=0; memory contents not reset.
REQ-033 Reset mid-WAIT SHALL abort the access with no memory write.

Structure
REQ-034 Shared package holds WB bit positions, FSM state encoding, DEPTH default, address index slice.
REQ-035 One sub-module mem2wb: MEM/WB pipeline register with async active-low reset and bubble input.

Verification
REQ-036 WAIT_CYCLES=1: store 0xDEADBEEF @0x10 -> stall high 1 cycle, no write until second edge; later load @0x10 -> ReadData=0xDEADBEEF, Wb=10 and 11 respectively.
REQ-037 WAIT_CYCLES=0: back-to-back store @0x4 value 5, load @0x4 -> no stall, ReadData=5 next cycle.
REQ-038 Mem_Br=1, Zero=1 -> PCSrc=1 same cycle; Zero=0 -> PCSrc=0; during stall unchanged rule.
REQ-039 Store @0x6 -> misalign=1 sticky, memory word 1 unchanged, no stall.
REQ-040 WAIT_CYCLES=3, rst low during second WAIT cycle -> outputs 0, IDLE, target word unchanged.
REQ-041 Stall cycles -> Wb=00 bubble each stall cycle; ALU op (no access) -> Wb, ALUResult, Write_Register follow inputs with 1-cycle latency.
